vram_access_arbiter: RTL and testbench

VRAM_ACCESS_ARBITER -- requirements
Module: vram_access_arbiter

---
 rtl/vram_arb_pkg.sv | 14 +
 rtl/vram_read_return.sv | 50 +++++
 rtl/vram_access_arbiter.sv | 119 +++++++++++
 tb/tb_vram_access_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and default sizing for the VRAM access arbiter.
package vram_arb_pkg;

    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_DISP = 2'd1,
        OWNER_HOST = 2'd2
    } owner_e;

endpackage

// File: rtl/vram_read_return.sv
// Read-return path: carries the owner tag of each read alongside the memory
// latency and routes the returned word to the display or host port.
module vram_read_return
    import vram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_vld,
    input  owner_e                rd_owner,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  disp_rvalid,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata
);

    logic   vld_p1;
    owner_e owner_p1;

    // stage 1: tag held while the memory presents read data
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            owner_p1 <= OWNER_NONE;
        end else begin
            vld_p1   <= rd_vld;
            owner_p1 <= rd_owner;
        end
    end

    // stage 2: capture mem_rdata into the owner's port; rdata holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            disp_rdata  <= '0;
            host_rdata  <= '0;
        end else begin
            disp_rvalid <= vld_p1 && (owner_p1 == OWNER_DISP);
            host_rvalid <= vld_p1 && (owner_p1 == OWNER_HOST);
            if (vld_p1 && (owner_p1 == OWNER_DISP))
                disp_rdata <= mem_rdata;
            if (vld_p1 && (owner_p1 == OWNER_HOST))
                host_rdata <= mem_rdata;
        end
    end

endmodule

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM arbiter between display fetch and host access; display wins in
// active video, host wins in blanking. Define VRAM_ARB_STARVE_GUARD_EN to force a
// host grant after STARVE_LIMIT cycles of waiting.
module vram_access_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hblank,
    input  logic                  vblank,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_ack,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    output logic                  disp_rvalid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    owner_e owner_q;
    owner_e owner_d;
    logic   blank;
    logic   host_force;

    assign blank = hblank | vblank;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign host_force = (wait_cnt == CNT_W'(STARVE_LIMIT));

    // Counts cycles the host has been refused; saturates so the force stays asserted.
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (!host_req || (owner_d == OWNER_HOST))
            wait_cnt <= '0;
        else if (!host_force)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end
`else
    assign host_force = 1'b0;
`endif

    always_comb begin
        owner_d = OWNER_NONE;
        if (host_req && (blank || !disp_req || host_force))
            owner_d = OWNER_HOST;
        else if (disp_req)
            owner_d = OWNER_DISP;
    end

    always_ff @(posedge clk) begin
        if (reset)
            owner_q <= OWNER_NONE;
        else
            owner_q <= owner_d;
    end

    // grant stage: ack pulse and memory strobe; address/data hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_ack  <= 1'b0;
            host_ack  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            disp_ack <= (owner_d == OWNER_DISP);
            host_ack <= (owner_d == OWNER_HOST);
            mem_en   <= (owner_d != OWNER_NONE);
            mem_we   <= (owner_d == OWNER_HOST) && host_we;
            case (owner_d)
                OWNER_DISP: mem_addr <= disp_addr;
                OWNER_HOST: begin
                    mem_addr  <= host_addr;
                    mem_wdata <= host_wdata;
                end
                default: ;
            endcase
        end
    end

    vram_read_return #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_read_return (
        .clk         (clk),
        .reset       (reset),
        .rd_vld      (mem_en && !mem_we),
        .rd_owner    (owner_q),
        .mem_rdata   (mem_rdata),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Scoreboard bench for vram_access_arbiter: a cycle-level reference model predicts
// every output, a monitor compares them, and directed scenarios check key timings.
module tb_vram_access_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LIMIT = 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hblank = 1'b0, vblank = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_ack, disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vram_access_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .hblank(hblank), .vblank(vblank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] vinit(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'h3C, ~a[7:0]};
    endfunction

    // Behavioural VRAM: read data appears the cycle after the read strobe.
    logic [DW-1:0] vram [int];
    initial begin : vram_dev
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en && !mem_we)
                mem_rdata <= vram.exists(int'(mem_addr)) ? vram[int'(mem_addr)] : vinit(mem_addr);
            if (mem_en && mem_we)
                vram[int'(mem_addr)] = mem_wdata;
        end
    end

    // Requester agents: hold req and payload until ack, then present the next item.
    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wd; } hreq_t;
    logic [AW-1:0] dq[$];
    hreq_t         hq[$];

    task automatic push_host(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        hreq_t h;
        h.we = we; h.addr = a; h.wd = d;
        hq.push_back(h);
    endtask

    initial begin : driver
        forever begin
            @(posedge clk);
            #1;
            if (disp_ack && dq.size() > 0) void'(dq.pop_front());
            if (host_ack && hq.size() > 0) void'(hq.pop_front());
            disp_req = (dq.size() > 0);
            if (dq.size() > 0) disp_addr = dq[0];
            host_req = (hq.size() > 0);
            if (hq.size() > 0) begin
                host_we    = hq[0].we;
                host_addr  = hq[0].addr;
                host_wdata = hq[0].wd;
            end
        end
    end

    // Reference model: predicts the outputs seen after every edge.
    typedef struct {
        logic da, ha, me, mw, dv, hv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md, dd, hd;
    } snap_t;
    typedef struct { bit host; logic [DW-1:0] data; int due; } ret_t;

    snap_t         exp_q[$];
    ret_t          infl[$];
    logic [DW-1:0] shadow [int];

    function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return vinit(a);
    endfunction

    initial begin : model
        snap_t s;
        ret_t  r;
        int    cyc, hwait;
        bit    hw, dw, fh;
        cyc = 0; hwait = 0;
        s.ma = '0; s.md = '0; s.dd = '0; s.hd = '0;
        forever begin
            @(posedge clk);
            cyc++;
            s.da = 0; s.ha = 0; s.me = 0; s.mw = 0; s.dv = 0; s.hv = 0;
            if (reset) begin
                s.ma = '0; s.md = '0; s.dd = '0; s.hd = '0;
                infl.delete();
                hwait = 0;
            end else begin
                if (infl.size() > 0 && infl[0].due == cyc) begin
                    if (infl[0].host) begin s.hv = 1; s.hd = infl[0].data; end
                    else begin s.dv = 1; s.dd = infl[0].data; end
                    void'(infl.pop_front());
                end
                fh = GUARD && (hwait == LIMIT);
                hw = host_req && ((hblank || vblank) || !disp_req || fh);
                dw = disp_req && !hw;
                if (hw) begin
                    s.ha = 1; s.me = 1; s.mw = host_we; s.ma = host_addr; s.md = host_wdata;
                    if (host_we) shadow[int'(host_addr)] = host_wdata;
                    else begin r.host = 1; r.data = peek(host_addr); r.due = cyc + 2; infl.push_back(r); end
                end else if (dw) begin
                    s.da = 1; s.me = 1; s.ma = disp_addr;
                    r.host = 0; r.data = peek(disp_addr); r.due = cyc + 2; infl.push_back(r);
                end
                if (hw || !host_req) hwait = 0;
                else if (hwait < LIMIT) hwait++;
            end
            exp_q.push_back(s);
        end
    end

    initial begin : monitor
        snap_t s;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("scoreboard underrun", 32'(exp_q.size()), 32'd1);
            end else begin
                s = exp_q.pop_front();
                chk("disp_ack",    32'(disp_ack),    32'(s.da));
                chk("host_ack",    32'(host_ack),    32'(s.ha));
                chk("mem_en",      32'(mem_en),      32'(s.me));
                chk("mem_we",      32'(mem_we),      32'(s.mw));
                chk("mem_addr",    32'(mem_addr),    32'(s.ma));
                chk("mem_wdata",   32'(mem_wdata),   32'(s.md));
                chk("disp_rvalid", 32'(disp_rvalid), 32'(s.dv));
                chk("host_rvalid", 32'(host_rvalid), 32'(s.hv));
                chk("disp_rdata",  32'(disp_rdata),  32'(s.dd));
                chk("host_rdata",  32'(host_rdata),  32'(s.hd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((dq.size() > 0 || hq.size() > 0) && n < 500) begin tick(); n++; end
        chk("drain timeout", 32'(dq.size() + hq.size()), 32'd0);
        repeat (4) tick();
    endtask

    initial begin : test
        int  k;
        bit  seen;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("reset mem_en", 32'(mem_en), 32'd0);
        chk("reset disp_ack", 32'(disp_ack), 32'd0);
        tick();

        // both read, active video: display first, returns in order
        @(negedge clk);
        dq.push_back(16'h0100);
        push_host(1'b0, 16'h0200, 16'h0000);
        tick();
        tick(); chk("c1 disp_ack", 32'(disp_ack), 32'd1); chk("c1 host_ack", 32'(host_ack), 32'd0);
        tick(); chk("c2 host_ack", 32'(host_ack), 32'd1);
        tick(); chk("c3 disp_rvalid", 32'(disp_rvalid), 32'd1);
                chk("c3 disp_rdata", 32'(disp_rdata), 32'(vinit(16'h0100)));
        tick(); chk("c4 host_rvalid", 32'(host_rvalid), 32'd1);
                chk("c4 host_rdata", 32'(host_rdata), 32'(vinit(16'h0200)));
        repeat (3) tick();

        // hblank: host first, then a host write with no read return
        @(negedge clk);
        hblank = 1'b1;
        dq.push_back(16'h0300);
        push_host(1'b0, 16'h0400, 16'h0000);
        tick();
        tick(); chk("hb host_ack first", 32'(host_ack), 32'd1); chk("hb disp_ack wait", 32'(disp_ack), 32'd0);
        tick(); chk("hb disp_ack second", 32'(disp_ack), 32'd1);
        repeat (2) tick();
        @(negedge clk);
        push_host(1'b1, 16'h0010, 16'h1234);
        tick();
        tick(); chk("wr host_ack", 32'(host_ack), 32'd1); chk("wr mem_we", 32'(mem_we), 32'd1);
                chk("wr mem_addr", 32'(mem_addr), 32'h0010); chk("wr mem_wdata", 32'(mem_wdata), 32'h1234);
        push_host(1'b0, 16'h0010, 16'h0000);
        tick(); chk("wr no rvalid a", 32'(host_rvalid), 32'd0);
        tick(); chk("wr no rvalid b", 32'(host_rvalid), 32'd0);
        repeat (4) tick();
        @(negedge clk);
        hblank = 1'b0;
        tick();

        // display streaming 0..7
        @(negedge clk);
        for (int i = 0; i < 8; i++) dq.push_back(AW'(i));
        tick();
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j <= 8) begin
                chk("stream mem_en", 32'(mem_en), 32'd1);
                chk("stream mem_addr", 32'(mem_addr), 32'(j - 1));
            end
            if (j >= 3) begin
                chk("stream rvalid", 32'(disp_rvalid), 32'd1);
                chk("stream rdata", 32'(disp_rdata), 32'(vinit(AW'(j - 3))));
            end
        end
        repeat (3) tick();

        // continuous display with a waiting host in active video
        @(negedge clk);
        for (int i = 0; i < (GUARD ? 20 : 110); i++) dq.push_back(AW'(16'h1000 + i));
        push_host(1'b0, 16'h2000, 16'h0000);
        tick();
        k = 0; seen = 0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        for (int i = 1; i <= 30 && !seen; i++) begin
            tick();
            if (host_ack) begin seen = 1; k = i; end
        end
        chk("starve grant cycle", 32'(k), 32'(LIMIT + 1));
        tick(); chk("starve disp resumes", 32'(disp_ack), 32'd1);
`else
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (host_ack) seen = 1;
        end
        chk("no guard host starved", 32'(seen), 32'd0);
        vblank = 1'b1;
        tick(); chk("vblank host_ack", 32'(host_ack), 32'd1);
        vblank = 1'b0;
`endif
        drain();

        // reset one cycle after a display ack discards the read in flight
        @(negedge clk);
        dq.push_back(16'h0050);
        tick();
        tick(); chk("rst pre ack", 32'(disp_ack), 32'd1);
        reset = 1'b1;
        dq.push_back(16'h0060);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst disp_rvalid", 32'(disp_rvalid), 32'd0);
            chk("rst outputs", 32'({disp_ack, host_ack, host_rvalid, mem_en, mem_we}), 32'd0);
            chk("rst mem_addr", 32'(mem_addr), 32'd0);
            chk("rst rdata", 32'({disp_rdata, host_rdata}), 32'd0);
        end
        reset = 1'b0;
        tick(); chk("post rst ack", 32'(disp_ack), 32'd1); chk("post rst no rvalid a", 32'(disp_rvalid), 32'd0);
        tick(); chk("post rst no rvalid b", 32'(disp_rvalid), 32'd0);
        tick(); chk("post rst rvalid", 32'(disp_rvalid), 32'd1);
                chk("post rst rdata", 32'(disp_rdata), 32'(vinit(16'h0060)));
        repeat (2) tick();

        // randomized traffic and blanking
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hblank = ($urandom_range(3) == 0);
            vblank = ($urandom_range(7) == 0);
            if (dq.size() < 3 && $urandom_range(1) == 1)
                dq.push_back(AW'($urandom_range(31)));
            if (hq.size() < 3 && $urandom_range(2) == 0)
                push_host(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom));
        end
        @(negedge clk);
        hblank = 1'b0;
        vblank = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
